updi_sync_rx: RTL
=================

# updi_sync_rx

Target-side UART receiver for the single-wire UPDI link, with automatic baud detection from the 0x55 SYNCH character. It sits on the responder end of the link and mirrors the host's transmitter: it measures the SYNCH character to derive the bit period, then receives 8-bit, parity-protected frames at that rate. It also detects BREAK conditions and reports errors.

## Interface
- PARITY_BIT, "even": "none", "even" or "odd".
- STOP_BITS, 2: number of stop bits, 1 or 2; every stop bit is checked.
- DIV_WIDTH, 16: width of the bit-period counter and of `baud_div`.
- MIN_DIV, 4: smallest accepted bit period, in clk cycles.
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- rx, input, 1: asynchronous UPDI line; idles high.
- relock, input, 1: one-cycle pulse that drops the lock and rearms SYNCH measurement.
- rx_data, output, 8: last received byte, LSB-first on the wire; holds until the next frame.
- rx_data_valid, output, 1: one-cycle pulse when a frame completes.
- rx_error, output, 1: one-cycle pulse on a parity, framing, SYNCH-timeout or too-fast SYNCH error.
- break_detected, output, 1: one-cycle pulse when a BREAK is recognised.
- baud_locked, output, 1: high while `baud_div` is valid.
- baud_div, output, DIV_WIDTH: measured bit period in clk cycles.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1), then a falling-edge detector. All states act on the synchronised line.
- States:
  - UNLOCKED: wait for a falling edge, then go to SYNC_MEASURE.
  - SYNC_MEASURE:
    - Count cycles from the first falling edge to the 5th falling edge; this span is 8 bit times.
    - `baud_div` = (count + 4) >> 3.
    - Then wait for the line to go high, which is the SYNCH stop bit.
    - Then set `baud_locked` and go to IDLE.
    - The SYNCH byte is consumed and never delivered on `rx_data`.
  - IDLE: a falling edge starts a frame and moves to START.
  - START: re-sample the line at `baud_div` >> 1.
    - Line high: false start; return to IDLE with no error.
    - Line low: move to DATA.
  - DATA: sample 8 bits at `baud_div` intervals.
  - PARITY: sample one bit. This state is skipped when PARITY_BIT is "none".
  - STOP: sample STOP_BITS bits.
    - At the final stop sample, update `rx_data` and pulse `rx_data_valid`.
    - Pulse `rx_error` in the same cycle if the parity is wrong or any stop bit sampled 0.
    - After a stop sampled 0, wait for the line to go high before returning to IDLE.
  - WAIT_HIGH: wait for the line to go high, then go to UNLOCKED.
- SYNCH errors:
  - Counter saturates at 2^DIV_WIDTH − 1 during SYNC_MEASURE: pulse `rx_error`, go to WAIT_HIGH.
  - Computed `baud_div` < MIN_DIV: pulse `rx_error`, go to WAIT_HIGH.
  - In both cases `baud_locked` stays 0.
- `relock` forces UNLOCKED and clears `baud_locked` in the next cycle, regardless of state. An in-flight frame is discarded with no pulse. Reset has priority over `relock`.

## Timing
- Reset values:
  - `rx_data` = 0, `baud_div` = 0.
  - `rx_data_valid`, `rx_error`, `break_detected` and `baud_locked` = 0.
  - State = UNLOCKED.
- Input latency: 2 cycles from a `rx` change to the synchronised line.
- `baud_locked` rises 1 cycle after the synchronised rising edge of the SYNCH stop bit.
- Bit sampling:
  - Data bit n (0..7) is sampled `baud_div`·(n+1) + `baud_div`>>1 cycles after the synchronised start edge.
  - `rx_data_valid` is asserted in the cycle of the last stop-bit sample.
- A falling edge in the same cycle as the final stop sample is missed; the next frame needs 1 cycle of idle-high.
- Reset mid-frame: no pulse; all outputs return to their reset values next cycle.

## Configuration
- Macro: `UPDI_SYNC_RX_BREAK_EN`.
- Defined:
  - While locked, a continuous low of ≥ 12·`baud_div` cycles pulses `break_detected` once.
  - It also clears `baud_locked`, suppresses that frame's `rx_data_valid`/`rx_error`, and moves to WAIT_HIGH.
  - While unlocked, a long low resolves via the SYNCH-timeout path.
- Undefined:
  - The low-run counter is not built and `break_detected` is tied to 0.
  - A BREAK shows up as a 0x00 frame with `rx_error` (framing error); the lock is kept.

## Structure
- `updi_pkg` holds:
  - the state enum `updi_rx_state`;
  - `UPDI_SYNC_CHAR` = 8'h55;
  - `UPDI_BREAK_BITS` = 12;
  - `UPDI_SYNC_EDGES` = 5.
- Sub-module `updi_line_sync`: 2-flop synchroniser plus falling/rising edge strobes, reset to idle-high. It is reused by the future half-duplex PHY.

## Test plan
- Lock: 0x55 at 20 clk/bit, then 0xA5 with even parity and 2 stops -> `baud_div` = 20, `baud_locked` = 1, one `rx_data_valid` with `rx_data` = 0xA5, no error.
- Parity error: locked at 20; send 0x3C with the parity bit flipped -> `rx_data_valid` and `rx_error` pulse together, `rx_data` = 0x3C.
- Framing error: second stop bit driven 0 -> `rx_error` pulse. Next well-formed byte 0x01 is received cleanly.
- Glitch and too-fast SYNCH:
  - Locked; 5-cycle low glitch -> false start, no pulses.
  - Separately, unlocked; SYNCH at 3 clk/bit -> `rx_error`, `baud_locked` stays 0.
- BREAK (macro defined): locked at 20; hold low for 300 cycles -> `break_detected` pulse at cycle 240 of the low, `baud_locked` drops. A following SYNCH at 40 clk/bit relocks to `baud_div` = 40.
- `relock` mid-frame at cycle 50 of 0x77 -> no `rx_data_valid`, `baud_locked` = 0 next cycle. A new SYNCH at 16 clk/bit relocks.

Source files
------------

// File: rtl/updi_pkg.sv
// updi_pkg: shared definitions for the UPDI receive path.
//   updi_rx_state   - receiver FSM state encoding
//   UPDI_SYNC_CHAR  - SYNCH character value (0x55)
//   UPDI_BREAK_BITS - BREAK length in bit times
//   UPDI_SYNC_EDGES - falling edges measured across one SYNCH character
package updi_pkg;

  typedef enum logic [3:0] {
    ST_UNLOCKED     = 4'd0,
    ST_SYNC_MEASURE = 4'd1,
    ST_IDLE         = 4'd2,
    ST_START        = 4'd3,
    ST_DATA         = 4'd4,
    ST_PARITY       = 4'd5,
    ST_STOP         = 4'd6,
    ST_STOP_WAIT    = 4'd7,  // stop sampled low: wait for line high, then IDLE
    ST_WAIT_HIGH    = 4'd8
  } updi_rx_state;

  localparam logic [7:0] UPDI_SYNC_CHAR  = 8'h55;
  localparam int         UPDI_BREAK_BITS = 12;
  localparam int         UPDI_SYNC_EDGES = 5;

endpackage

// File: rtl/updi_line_sync.sv
// updi_line_sync: 2-flop synchroniser for the asynchronous UPDI line plus
// single-cycle edge strobes. All flops reset to the idle-high level so no
// spurious edge appears when reset is released.
//   clk, rst - clock, synchronous active-high reset
//   i_rx     - asynchronous line input
//   o_line   - synchronised line level
//   o_fall   - high for one cycle when o_line goes 1 -> 0
//   o_rise   - high for one cycle when o_line goes 0 -> 1
module updi_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_line,
  output logic o_fall,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_line = r_sync;
  assign o_fall = r_prev & ~r_sync;
  assign o_rise = ~r_prev & r_sync;

endmodule

// File: rtl/updi_sync_rx.sv
// updi_sync_rx: UPDI target-side UART receiver with baud detection from the
// 0x55 SYNCH character, parity/stop checking and optional BREAK detection.
//   clk, rst       - clock, synchronous active-high reset
//   rx             - asynchronous UPDI line (idles high)
//   relock         - pulse: drop lock and re-measure SYNCH
//   rx_data        - last received byte
//   rx_data_valid  - one-cycle pulse per completed frame
//   rx_error       - one-cycle pulse on parity/framing/SYNCH error
//   break_detected - one-cycle pulse on BREAK
//   baud_locked    - baud_div is valid
//   baud_div       - measured bit period in clk cycles
// Optional feature macro: UPDI_SYNC_RX_BREAK_EN (BREAK detection). When it is
// undefined no low-run counter exists and break_detected is tied low.
module updi_sync_rx
  import updi_pkg::*;
#(
  parameter string PARITY_BIT = "even",
  parameter int    STOP_BITS  = 2,
  parameter int    DIV_WIDTH  = 16,
  parameter int    MIN_DIV    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 relock,
  output logic [7:0]           rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_error,
  output logic                 break_detected,
  output logic                 baud_locked,
  output logic [DIV_WIDTH-1:0] baud_div
);

  localparam bit                   PAR_EN    = (PARITY_BIT != "none");
  localparam bit                   PAR_ODD   = (PARITY_BIT == "odd");
  localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   MIN_DIV_W = (DIV_WIDTH+1)'(MIN_DIV);
  localparam logic [2:0]           EDGES_W   = 3'(UPDI_SYNC_EDGES);
  localparam logic [2:0]           LAST_STOP = 3'(STOP_BITS - 1);

  logic w_line, w_fall, w_rise;

  updi_line_sync u_line_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (rx),
    .o_line (w_line),
    .o_fall (w_fall),
    .o_rise (w_rise)
  );

  updi_rx_state         r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_baud_div;
  logic [2:0]           r_edges;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic [7:0]           r_rx_data;
  logic                 r_par, r_par_err, r_stop_err, r_defer;
  logic                 r_locked, r_valid, r_error;

  // Span of 8 bit times, rounded to the nearest bit period.
  logic [DIV_WIDTH:0]   w_div_calc;
  logic [DIV_WIDTH-1:0] w_half;
  logic                 w_cnt_sat;
  logic                 w_frame_err;
  logic                 w_stop_defer;
  logic                 w_break;

  assign w_div_calc  = ({1'b0, r_cnt} + (DIV_WIDTH+1)'(4)) >> 3;
  assign w_half      = r_baud_div >> 1;
  assign w_cnt_sat   = &r_cnt;
  assign w_frame_err = r_par_err | r_stop_err | ~w_line;

`ifdef UPDI_SYNC_RX_BREAK_EN
  logic [DIV_WIDTH+3:0] r_low_cnt;
  logic [DIV_WIDTH+3:0] w_break_thr;
  logic                 r_break;
  logic                 r_seen_high;

  assign w_break_thr = (DIV_WIDTH+4)'(r_baud_div) * (DIV_WIDTH+4)'(UPDI_BREAK_BITS);
  // r_low_cnt lags the low run by one cycle, hence the -1.
  assign w_break = r_locked & ~w_line & (r_low_cnt >= w_break_thr - (DIV_WIDTH+4)'(1));
  // A frame that was low at every point may be the start of a BREAK: hold
  // its result until the line either rises or the BREAK threshold is hit.
  assign w_stop_defer   = ~r_seen_high & ~w_line;
  assign break_detected = r_break;

  always_ff @(posedge clk) begin
    if (rst || w_line || !r_locked) begin
      r_low_cnt <= '0;
    end else if (!(&r_low_cnt)) begin
      r_low_cnt <= r_low_cnt + (DIV_WIDTH+4)'(1);
    end
  end
`else
  assign w_break        = 1'b0;
  assign w_stop_defer   = 1'b0;
  assign break_detected = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_UNLOCKED;
      r_cnt      <= '0;
      r_baud_div <= '0;
      r_edges    <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_par      <= 1'b0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
      r_defer    <= 1'b0;
      r_locked   <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
`ifdef UPDI_SYNC_RX_BREAK_EN
      r_break     <= 1'b0;
      r_seen_high <= 1'b1;
`endif
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
`ifdef UPDI_SYNC_RX_BREAK_EN
      r_break     <= 1'b0;
      r_seen_high <= r_seen_high | w_line;
`endif
      if (relock) begin
        r_state  <= ST_UNLOCKED;
        r_locked <= 1'b0;
        r_defer  <= 1'b0;
      end else if (w_break) begin
`ifdef UPDI_SYNC_RX_BREAK_EN
        r_break  <= 1'b1;
`endif
        r_locked <= 1'b0;
        r_defer  <= 1'b0;
        r_state  <= ST_WAIT_HIGH;
      end else begin
        case (r_state)
          ST_UNLOCKED: begin
            if (w_fall) begin
              r_cnt   <= CNT_ONE;
              r_edges <= 3'd1;
              r_state <= ST_SYNC_MEASURE;
            end
          end
          ST_SYNC_MEASURE: begin
            if (r_edges == EDGES_W) begin
              // All edges seen; the rise is the SYNCH stop bit.
              if (w_rise) begin
                r_locked <= 1'b1;
                r_state  <= ST_IDLE;
              end
            end else if (w_fall && (r_edges == EDGES_W - 3'd1)) begin
              r_edges <= EDGES_W;
              if (w_div_calc < MIN_DIV_W) begin
                r_error <= 1'b1;
                r_state <= ST_WAIT_HIGH;
              end else begin
                r_baud_div <= w_div_calc[DIV_WIDTH-1:0];
              end
            end else if (w_cnt_sat) begin
              r_error <= 1'b1;
              r_state <= ST_WAIT_HIGH;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              if (w_fall) r_edges <= r_edges + 3'd1;
            end
          end
          ST_IDLE: begin
            if (w_fall) begin
              r_cnt   <= CNT_ONE;
              r_state <= ST_START;
`ifdef UPDI_SYNC_RX_BREAK_EN
              r_seen_high <= 1'b0;
`endif
            end
          end
          ST_START: begin
            if (r_cnt == w_half) begin
              r_cnt      <= CNT_ONE;
              r_bit_cnt  <= '0;
              r_par      <= 1'b0;
              r_par_err  <= 1'b0;
              r_stop_err <= 1'b0;
              r_state    <= w_line ? ST_IDLE : ST_DATA;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_DATA: begin
            if (r_cnt == r_baud_div) begin
              r_cnt     <= CNT_ONE;
              r_shift   <= {w_line, r_shift[7:1]};
              r_par     <= r_par ^ w_line;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_PARITY: begin
            if (r_cnt == r_baud_div) begin
              r_cnt     <= CNT_ONE;
              r_par_err <= r_par ^ w_line ^ PAR_ODD;
              r_state   <= ST_STOP;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_STOP: begin
            if (r_cnt == r_baud_div) begin
              r_cnt <= CNT_ONE;
              if (r_bit_cnt == LAST_STOP) begin
                if (w_stop_defer) begin
                  r_defer <= 1'b1;
                end else begin
                  r_rx_data <= r_shift;
                  r_valid   <= 1'b1;
                  r_error   <= w_frame_err;
                end
                r_state <= w_line ? ST_IDLE : ST_STOP_WAIT;
              end else begin
                r_stop_err <= r_stop_err | ~w_line;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_STOP_WAIT: begin
            if (w_line) begin
              // A held-back all-low frame turned out not to be a BREAK.
              if (r_defer) begin
                r_rx_data <= r_shift;
                r_valid   <= 1'b1;
                r_error   <= 1'b1;
                r_defer   <= 1'b0;
              end
              r_state <= ST_IDLE;
            end
          end
          ST_WAIT_HIGH: begin
            if (w_line) r_state <= ST_UNLOCKED;
          end
          default: r_state <= ST_UNLOCKED;
        endcase
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_data_valid = r_valid;
  assign rx_error      = r_error;
  assign baud_locked   = r_locked;
  assign baud_div      = r_baud_div;

endmodule
